tdm_burst_demux: RTL
====================

// Module: tdm_burst_demux
// PURPOSE
// - De-interleaves 2-channel TDM data bursts (ch0,ch1,ch0,ch1,...) into aligned word pairs.
// - Feeds din0/din1 of post_processing at 100MHz system clock; source end of that lane pair.
// - Small pair FIFO absorbs burst/consumer rate mismatch; flags framing errors and overflow.
// PARAMETERS
// - DATA_W  16  width of one TDM word / one output lane
// - DEPTH   8   pair FIFO depth in {ch0,ch1} entries; power of 2, >= 2
// PORTS
// - clk        in   1                  system clock, 100MHz
// - rst_n      in   1                  synchronous reset, active-low
// - in_valid   in   1                  in_data valid this cycle (no backpressure on input)
// - in_sof     in   1                  qualifies first word of a burst (ch0 slot)
// - in_last    in   1                  qualifies last word of a burst
// - in_data    in   DATA_W             TDM word
// - out_valid  out  1                  head pair available
// - out_ready  in   1                  consumer takes head pair when out_valid & out_ready
// - out_din0   out  DATA_W             ch0 word of head pair
// - out_din1   out  DATA_W             ch1 word of head pair
// - level      out  $clog2(DEPTH)+1    pairs currently stored
// - overflow   out  1                  sticky: pair dropped because FIFO full
// - frame_err  out  1                  sticky: orphan word/partial pair discarded
// - pair_cnt   out  32                 pairs written to FIFO (TDM_STATS_EN)
// - drop_cnt   out  16                 words discarded, any cause (TDM_STATS_EN)
// BEHAVIOUR
// - Interface: one clock (clk); reset is synchronous, active-low (rst_n), applied on posedge clk.
// - Reset: FSM=IDLE, FIFO empty, out_valid=0, out_din0/out_din1=0, level=0, overflow=0,
//   frame_err=0, pair_cnt=0, drop_cnt=0. Reset mid-burst discards held ch0 word and all pairs.
// - FSM (advances only on in_valid; words with in_valid=0 are ignored):
//   IDLE: sof -> capture ch0 -> CH1. Non-sof word -> discard, frame_err=1 -> IDLE.
//   CH0 : sof -> capture ch0 -> CH1 (resync, no error). Non-sof word -> capture ch0 -> CH1.
//   CH1 : non-sof word -> form pair {held ch0, word}, push; -> IDLE if in_last else CH0.
//         sof -> held ch0 discarded, frame_err=1, new word captured as ch0 -> CH1.
//   sof & last same word: captured as ch0, then treated as orphan: discard, frame_err=1 -> IDLE.
//   in_last on a ch0 slot (CH0 or IDLE with sof): discard word, frame_err=1 -> IDLE.
// - Push: accepted if level < DEPTH, or level == DEPTH and a pop occurs the same cycle.
//   Otherwise pair dropped, overflow=1, drop_cnt += 2. FIFO contents unchanged.
// - FIFO is first-word-fall-through; out_din0/out_din1 are registered from head entry.
// - Latency: ch1 word at posedge N into empty FIFO -> out_valid=1 with pair after posedge N+1.
// - Pop: out_valid & out_ready. Simultaneous push+pop: level unchanged, ordering preserved.
// - out_valid=0: out_din0/out_din1 hold last presented values (no X, no zeroing).
// - level exact every cycle; pointers wrap modulo DEPTH; level saturates logically at DEPTH.
// - Sticky flags clear only on reset. pair_cnt and drop_cnt wrap modulo 2^width.
// - No arithmetic on data; words pass bit-exact, ch0 always on out_din0.
// CONFIGURATION
// - TDM_STATS_EN defined: pair_cnt and drop_cnt counters implemented as above; each
//   orphan/framing discard adds 1 to drop_cnt, each overflow drop adds 2.
// - TDM_STATS_EN undefined: counters not built; pair_cnt and drop_cnt tied to 0.
//   All other behaviour identical.
// TESTING
// - Burst 0x0001(sof),0x0002,0x0003,0x0004(last), out_ready=1 -> pairs {1,2},{3,4}; first
//   out_valid the cycle after 0x0002; frame_err=0, overflow=0.
// - out_ready=0, 9 pairs pushed, DEPTH=8 -> level=8, overflow=1, 9th pair absent; drain
//   yields the first 8 pairs in order; drop_cnt=2 (stats on).
// - level=8, push and pop same cycle -> push accepted, level stays 8, overflow stays 0.
// - Burst 0xA(sof),0xB,0xC(sof),0xD(last) -> pairs {A,B},{C,D}; frame_err=0.
// - Burst 0x10(sof),0x11,0x12(last) -> pair {10,11} only, frame_err=1, drop_cnt=1.
// - rst_n=0 for one cycle while CH1 with 3 pairs stored -> next cycle out_valid=0, level=0,
//   flags/counters 0; next sof burst processed normally.

Source files
------------

// File: rtl/tdm_burst_demux.sv
// rtl/tdm_burst_demux.sv - 2-channel TDM burst de-interleaver feeding a small pair FIFO
// Optional stats counters (pair_cnt, drop_cnt) are built when TDM_STATS_EN is defined.
module tdm_burst_demux #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic                     in_last,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_din0,
  output logic [DATA_W-1:0]        out_din1,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     frame_err,
  output logic [31:0]              pair_cnt,
  output logic [15:0]              drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CH0, ST_CH1} state_t;

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       hold_q, hold_d;
  logic [2*DATA_W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic                    out_valid_q;
  logic [DATA_W-1:0]       out_din0_q, out_din1_q;
  logic                    overflow_q, frame_err_q;

  logic                    push_req, push_acc, pop, ovf_set, err_set, head_valid;
  logic [1:0]              discard_n;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    push_req  = 1'b0;
    err_set   = 1'b0;
    discard_n = 2'd0;
    if (in_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_sof && !in_last) begin
            hold_d  = in_data;
            state_d = ST_CH1;
          end else begin
            err_set   = 1'b1;
            discard_n = 2'd1;
            state_d   = ST_IDLE;
          end
        end
        ST_CH0: begin
          if (in_last) begin
            err_set   = 1'b1;
            discard_n = 2'd1;
            state_d   = ST_IDLE;
          end else begin
            hold_d  = in_data;
            state_d = ST_CH1;
          end
        end
        ST_CH1: begin
          // A sof here orphans the held ch0; with last it orphans the new word too.
          if (in_sof) begin
            err_set = 1'b1;
            if (in_last) begin
              discard_n = 2'd2;
              state_d   = ST_IDLE;
            end else begin
              discard_n = 2'd1;
              hold_d    = in_data;
              state_d   = ST_CH1;
            end
          end else begin
            push_req = 1'b1;
            state_d  = in_last ? ST_IDLE : ST_CH0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign pop      = out_valid_q & out_ready;
  assign push_acc = push_req & ((level_q < LVL_W'(DEPTH)) | pop);
  assign ovf_set  = push_req & ~push_acc;
  assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  assign level_d  = level_q + LVL_W'(push_acc) - LVL_W'(pop);
  // Head presentation uses the pre-push level, giving one cycle of fall-through latency.
  assign head_valid = level_q > LVL_W'(pop);

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= {hold_q, in_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_din0_q  <= '0;
      out_din1_q  <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      wr_ptr_q    <= wr_ptr_q + PTR_W'(push_acc);
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= head_valid;
      if (head_valid) begin
        out_din0_q <= mem_q[rd_ptr_d][2*DATA_W-1:DATA_W];
        out_din1_q <= mem_q[rd_ptr_d][DATA_W-1:0];
      end
      overflow_q  <= overflow_q | ovf_set;
      frame_err_q <= frame_err_q | err_set;
    end
  end

  assign out_valid = out_valid_q;
  assign out_din0  = out_din0_q;
  assign out_din1  = out_din1_q;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

`ifdef TDM_STATS_EN
  logic [31:0] pair_cnt_q;
  logic [15:0] drop_cnt_q;
  logic [15:0] drop_inc;

  assign drop_inc = ovf_set ? 16'd2 : 16'(discard_n);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pair_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      pair_cnt_q <= pair_cnt_q + 32'(push_acc);
      drop_cnt_q <= drop_cnt_q + drop_inc;
    end
  end

  assign pair_cnt = pair_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = ^discard_n;
  assign pair_cnt     = 32'd0;
  assign drop_cnt     = 16'd0;
`endif

endmodule
